// File: rtl/multicycle_control.sv
// Multicycle control FSM for the 16-bit MIPS datapath; outputs decode combinationally from state.
// Optional MCCTRL_ILLEGAL_TRAP_EN: illegal opcodes enter HALT (left only by reset) instead of NOP.
module multicycle_control #(
  parameter int unsigned OPC_W   = 3,
  parameter int unsigned FUNCT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               sig_zero,
  input  logic               mem_ready,
  output logic [2:0]         sig_alu_control,
  output logic               sig_alu_src_a,
  output logic [1:0]         sig_alu_src_b,
  output logic               sig_pc_write,
  output logic [1:0]         sig_pc_source,
  output logic               sig_ir_write,
  output logic               sig_iord,
  output logic               sig_mem_read,
  output logic               sig_mem_write,
  output logic               sig_reg_write,
  output logic               sig_reg_dst,
  output logic               sig_mem_to_reg,
  output logic               sig_illegal,
  output logic [3:0]         sig_state
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEM_ADDR = 4'd2;
  localparam logic [3:0] MEM_RD   = 4'd3;
  localparam logic [3:0] MEM_WB   = 4'd4;
  localparam logic [3:0] MEM_WR   = 4'd5;
  localparam logic [3:0] EXEC     = 4'd6;
  localparam logic [3:0] ALU_WB   = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] JUMP     = 4'd9;
  localparam logic [3:0] ADDI_EX  = 4'd10;
  localparam logic [3:0] ADDI_WB  = 4'd11;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
  localparam logic [3:0] HALT     = 4'd12;
`endif

  localparam logic [OPC_W-1:0] OP_R    = OPC_W'(3'b000);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(3'b001);
  localparam logic [OPC_W-1:0] OP_J    = OPC_W'(3'b010);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(3'b100);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(3'b101);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(3'b110);

  logic [3:0] state_q, state_d;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and output decode.
  always_comb begin
    state_d         = state_q;
    sig_alu_control = 3'b000;
    sig_alu_src_a   = 1'b0;
    sig_alu_src_b   = 2'b00;
    sig_pc_write    = 1'b0;
    sig_pc_source   = 2'b00;
    sig_ir_write    = 1'b0;
    sig_iord        = 1'b0;
    sig_mem_read    = 1'b0;
    sig_mem_write   = 1'b0;
    sig_reg_write   = 1'b0;
    sig_reg_dst     = 1'b0;
    sig_mem_to_reg  = 1'b0;
    sig_illegal     = 1'b0;
    sig_state       = state_q;

    case (state_q)
      FETCH: begin
        sig_mem_read  = 1'b1;
        sig_alu_src_b = 2'b01;
        // Write enables are suppressed while reset is held.
        if (mem_ready && !reset) begin
          sig_ir_write = 1'b1;
          sig_pc_write = 1'b1;
          state_d      = DECODE;
        end
      end
      DECODE: begin
        sig_alu_src_b = 2'b10;
        case (opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_R:         state_d = EXEC;
          OP_ADDI:      state_d = ADDI_EX;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          default: begin
            sig_illegal = 1'b1;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
            state_d     = HALT;
`else
            state_d     = FETCH;
`endif
          end
        endcase
      end
      MEM_ADDR: begin
        sig_alu_src_a = 1'b1;
        sig_alu_src_b = 2'b10;
        state_d       = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        sig_mem_read = 1'b1;
        sig_iord     = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        sig_reg_write  = 1'b1;
        sig_mem_to_reg = 1'b1;
        state_d        = FETCH;
      end
      MEM_WR: begin
        sig_mem_write = 1'b1;
        sig_iord      = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXEC: begin
        sig_alu_src_a = 1'b1;
        // Unused funct codes fall back to add, like the ALU.
        if (funct <= FUNCT_W'(4)) sig_alu_control = 3'(funct);
        state_d = ALU_WB;
      end
      ALU_WB: begin
        sig_reg_write = 1'b1;
        sig_reg_dst   = 1'b1;
        state_d       = FETCH;
      end
      ADDI_EX: begin
        sig_alu_src_a = 1'b1;
        sig_alu_src_b = 2'b10;
        state_d       = ADDI_WB;
      end
      ADDI_WB: begin
        sig_reg_write = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        sig_alu_src_a   = 1'b1;
        sig_alu_control = 3'b001;
        sig_pc_source   = 2'b01;
        sig_pc_write    = sig_zero;
        state_d         = FETCH;
      end
      JUMP: begin
        sig_pc_write  = 1'b1;
        sig_pc_source = 2'b10;
        state_d       = FETCH;
      end
`ifdef MCCTRL_ILLEGAL_TRAP_EN
      HALT: state_d = HALT;
`endif
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control FSM for the 16-bit MIPS datapath.
- Drives the ALU's sig_alu_control and operand-select muxes, and consumes the ALU's sig_zero for branch resolution.
- Sequences fetch/decode/execute/memory/writeback and handshakes with instruction/data memory via mem_ready.
- Sits between the instruction register and the datapath muxes/register file/PC.

Parameters:
- OPC_W, 3, opcode field width (instr[15:13]); only 3 supported.
- FUNCT_W, 3, R-type funct width (instr[2:0]); only 3 supported.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  OPC_W  IR opcode field.
- funct  input  FUNCT_W  IR funct field.
- sig_zero  input  1  ALU zero flag (1 when ALU result == 0).
- mem_ready  input  1  memory access complete this cycle.
- sig_alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
- sig_alu_src_a  output  1  0=PC, 1=reg A.
- sig_alu_src_b  output  2  00=reg B, 01=const 1, 10=sign-ext imm, 11=reserved.
- sig_pc_write  output  1  PC load enable.
- sig_pc_source  output  2  00=ALU result, 01=ALUOut reg, 10=jump target.
- sig_ir_write  output  1  IR load enable.
- sig_iord  output  1  0=PC address, 1=ALUOut address.
- sig_mem_read  output  1  memory read request.
- sig_mem_write  output  1  memory write request.
- sig_reg_write  output  1  register file write enable.
- sig_reg_dst  output  1  0=rt, 1=rd.
- sig_mem_to_reg  output  1  0=ALUOut, 1=MDR.
- sig_illegal  output  1  one-cycle pulse on illegal opcode.
- sig_state  output  4  current state code, for debug.

Behaviour:
- Opcodes: 000 R-type, 001 addi, 100 lw, 101 sw, 110 beq, 010 j. All others are illegal.
- State codes:
  - 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_RD, 4 MEM_WB, 5 MEM_WR
  - 6 EXEC, 7 ALU_WB, 8 BRANCH, 9 JUMP, 10 ADDI_EX, 11 ADDI_WB, 12 HALT (HALT only with the optional feature).
- State register is updated on posedge clk. Reset forces FETCH asynchronously.
- Outputs are decoded combinationally from state and inputs. Every output is 0 unless listed for the current state; sig_alu_control defaults to 000. Hence, under reset, all outputs are 0 except the FETCH mem_read/alu_src_b values.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=000.
  - ir_write=1 and pc_write=1 (pc_source=00) only in the cycle mem_ready=1; then go to DECODE.
  - Otherwise hold in FETCH with no write enables.
- DECODE:
  - alu_src_a=0, alu_src_b=10, alu_control=000 (branch target precomputed into ALUOut).
  - Next state by opcode: lw/sw→MEM_ADDR, R→EXEC, addi→ADDI_EX, beq→BRANCH, j→JUMP.
  - Illegal opcode: pulse sig_illegal, then go to FETCH (treated as NOP).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_control=000. Next: lw→MEM_RD, sw→MEM_WR.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Next: FETCH.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready=1, then go to FETCH.
- EXEC:
  - alu_src_a=1, alu_src_b=00, alu_control=funct.
  - Funct 101–111 maps to 000 (add), matching the ALU default.
  - Next: ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_control=000. Next: ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_control=001, pc_source=01.
  - pc_write = sig_zero, evaluated combinationally in the same cycle.
  - Next: FETCH.
- JUMP: pc_write=1, pc_source=10. Next: FETCH.
- Latency with mem_ready tied high, in cycles including FETCH: R 4, addi 4, lw 5, sw 4, beq 3, j 3.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- Reset asserted mid-instruction aborts it: no partial write enables after reset is asserted. The FSM restarts in FETCH on the first edge after reset deasserts.

Optional Feature:
- Macro: MCCTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE pulses sig_illegal and enters HALT. HALT has all outputs 0 except sig_state=12 and is left only via reset.
- Undefined: HALT is not implemented, and an illegal opcode returns to FETCH as a NOP.

Test Plan:
- R-type sub (opcode 000, funct 001), mem_ready=1 → states 0,1,6,7,0; alu_control=001 in EXEC; reg_write=1, reg_dst=1 only in ALU_WB.
- lw with mem_ready low for 3 cycles in MEM_RD → MEM_RD held 4 cycles with mem_read=1, iord=1; reg_write=1, mem_to_reg=1 exactly once, in MEM_WB.
- beq with sig_zero=1 → pc_write=1, pc_source=01 in BRANCH. Repeat with sig_zero=0 → pc_write=0. Both return to FETCH after 3 cycles.
- FETCH with mem_ready=0 for 2 cycles, then 1 → ir_write and pc_write high only in the third cycle.
- Opcode 111 → sig_illegal single-cycle pulse. Without the macro: next state FETCH. With MCCTRL_ILLEGAL_TRAP_EN: sig_state=12, held until reset.
- Assert reset asynchronously during MEM_WR → sig_state=0 and mem_write=0 immediately, without waiting for a clock edge.
